fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 28 ++
 rtl/fifo_reader_skid_buf.sv | 75 +++++++
 rtl/fifo_reader.sv | 97 +++++++++
 tb/tb_fifo_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader_pkg
// Brief   : Shared types and sizing helpers for the fifo_reader block.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

   localparam int DATA_W_DFLT = 8;
   localparam int COUNT_W     = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // A depth of 1 still needs a one-bit pointer.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_reader_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : skid_buf
// Brief   : Circular output buffer with occupancy count; head word on data_o.
// Revision: 1.0 - initial release
// ============================================================================
module skid_buf
   import fifo_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int DEPTH  = 2,
   parameter int OCC_W  = occ_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [OCC_W-1:0]  occ_o
);

   localparam int PTR_W = ptr_width(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [OCC_W-1:0]  occ_q;
   logic              pop_ok;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign pop_ok  = pop_i && valid_o;
   assign valid_o = (occ_q != '0);
   assign data_o  = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         if (push_i && !pop_ok) begin
            occ_q <= occ_q + OCC_W'(1);
         end else if (!push_i && pop_ok) begin
            occ_q <= occ_q - OCC_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !rst) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      push_i |-> (occ_q != OCC_W'(DEPTH)));

   a_stall_stable: assert property (@(posedge clk) disable iff (rst)
      (valid_o && !pop_i) |=> $stable(data_o));

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_reader
// Brief   : Credit-based reader draining a 1-cycle-latency fifo into a skid
//           buffer with a valid/ready output and a delivered-word counter.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_reader
   import fifo_reader_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DFLT,
   parameter int SKID_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_enable,
   input  logic               in_fifo_empty,
   input  logic [DATA_W-1:0]  in_fifo_data,
   output logic               out_fifo_read,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               in_ready,
   output logic               out_busy,
   output logic [COUNT_W-1:0] out_count
);

   localparam int OCC_W = occ_width(SKID_DEPTH);

   state_e             state_q;
   logic               inflight_q;
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;
   logic [OCC_W-1:0]   w_occ;
   logic               w_credit_ok;
   logic               w_xfer;

   // A read is only issued when a slot is guaranteed for the returning word.
   assign w_credit_ok   = (int'(w_occ) + int'(inflight_q)) < SKID_DEPTH;
   assign out_fifo_read = (state_q == RUN) && !in_fifo_empty && w_credit_ok;
   assign w_xfer        = out_valid && in_ready;
   assign count_d       = w_xfer ? count_q + COUNT_W'(1) : count_q;
   assign out_count     = count_q;
   assign out_busy      = (state_q != IDLE) || (w_occ != '0) || inflight_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_enable) state_q <= RUN;
            end
            RUN: begin
               if (!in_enable) state_q <= DRAIN;
            end
            DRAIN: begin
               if (in_enable) begin
                  state_q <= RUN;
               end else if ((w_occ == '0) && !inflight_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= 1'b0;
         count_q    <= '0;
      end else begin
         inflight_q <= out_fifo_read;
         count_q    <= count_d;
      end
   end

   skid_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (SKID_DEPTH),
      .OCC_W  (OCC_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (in_fifo_data),
      .pop_i       (in_ready),
      .valid_o     (out_valid),
      .data_o      (out_data),
      .occ_o       (w_occ)
   );

   a_no_read_empty: assert property (@(posedge clk)
      in_fifo_empty |-> !out_fifo_read);

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_fifo_reader
// Brief   : Directed scoreboard bench for fifo_reader (depth 2 and depth 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fifo_reader;
   import fifo_reader_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_enable, in_fifo_empty, in_ready;
   logic [7:0]  in_fifo_data;
   logic        out_fifo_read, out_valid, out_busy;
   logic [7:0]  out_data;
   logic [15:0] out_count;

   logic        en4, empty4, ready4;
   logic [7:0]  data4;
   logic        rd4, valid4, busy4;
   logic [7:0]  odata4;
   logic [15:0] count4;

   always #5 clk = ~clk;

   fifo_reader #(.DATA_W(8), .SKID_DEPTH(2)) dut (
      .clk(clk), .rst(rst), .in_enable(in_enable), .in_fifo_empty(in_fifo_empty),
      .in_fifo_data(in_fifo_data), .out_fifo_read(out_fifo_read), .out_valid(out_valid),
      .out_data(out_data), .in_ready(in_ready), .out_busy(out_busy), .out_count(out_count)
   );

   fifo_reader #(.DATA_W(8), .SKID_DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_enable(en4), .in_fifo_empty(empty4),
      .in_fifo_data(data4), .out_fifo_read(rd4), .out_valid(valid4),
      .out_data(odata4), .in_ready(ready4), .out_busy(busy4), .out_count(count4)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] up_q[$];
   logic [7:0] exp_q[$];
   int         rd_cycles[$];
   int         cyc = 0, reads = 0, xfers = 0, valid_seen = 0, bad_rd = 0, first_valid = -1;
   int         r0, x0, v0, c0;
   logic [7:0] nxt4 = 8'h00, exp4 = 8'h00;
   int         x4 = 0, order_bad = 0;
   logic       rd_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock of the depth-2 DUT plus the 1-cycle-latency upstream fifo model.
   task automatic tick();
      logic       rd;
      logic [7:0] want;
      #2;
      rd = out_fifo_read;
      if (rd && in_fifo_empty) bad_rd++;
      if (out_valid) begin
         valid_seen++;
         if (first_valid < 0) first_valid = cyc;
      end
      if (out_valid && in_ready) begin
         xfers++;
         n_cmp++;
         assert (exp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL spurious_word: observed 0x%0h expected no word", out_data);
         end
         if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("word_order", 32'(out_data), 32'(want));
         end
      end
      if (rd) begin
         reads++;
         rd_cycles.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rd && up_q.size() > 0) begin
         in_fifo_data = up_q.pop_front();
         exp_q.push_back(in_fifo_data);
      end else begin
         in_fifo_data = 8'hEE;
      end
      in_fifo_empty = (up_q.size() == 0);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in_enable = 1'b0; in_fifo_empty = 1'b1; in_ready = 1'b0; in_fifo_data = 8'hEE;
      en4 = 1'b0; empty4 = 1'b1; ready4 = 1'b0; data4 = 8'hEE;
      tick();
      tick();
      chk("rst_read", 32'(out_fifo_read), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(out_busy), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_count4", 32'(count4), 32'd0);
      rst = 1'b0;
      tick();

      // Three-word stream with the consumer always ready.
      up_q = '{8'h11, 8'h22, 8'h33};
      in_fifo_empty = 1'b0; in_ready = 1'b1; in_enable = 1'b1;
      c0 = cyc; first_valid = -1;
      for (int i = 0; i < 30 && xfers < 3; i++) tick();
      chk("s1_xfers", 32'(xfers), 32'd3);
      chk("s1_reads", 32'(reads), 32'd3);
      chk("s1_first_read", 32'(rd_cycles[0]), 32'(c0 + 1));
      chk("s1_latency", 32'(first_valid - rd_cycles[0]), 32'd2);
      chk("s1_count", 32'(out_count), 32'd3);
      in_enable = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("s1_idle_busy", 32'(out_busy), 32'd0);

      // Stalled consumer: only the buffer depth worth of reads may be issued.
      r0 = reads; x0 = xfers;
      in_ready = 1'b0;
      up_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
      in_fifo_empty = 1'b0; in_enable = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("s2_reads", 32'(reads - r0), 32'd2);
      chk("s2_valid", 32'(out_valid), 32'd1);
      chk("s2_head", 32'(out_data), 32'h41);
      for (int i = 0; i < 3; i++) tick();
      chk("s2_head_hold", 32'(out_data), 32'h41);
      in_ready = 1'b1;
      for (int i = 0; i < 40 && (xfers - x0) < 5; i++) tick();
      chk("s2_xfers", 32'(xfers - x0), 32'd5);
      chk("s2_count", 32'(out_count), 32'd8);

      // Enable drops in the same cycle a read is issued.
      r0 = reads; x0 = xfers;
      up_q.push_back(8'h61);
      in_fifo_empty = 1'b0; in_enable = 1'b0;
      tick();
      chk("s3_read", 32'(reads - r0), 32'd1);
      chk("s3_drain", 32'(dut.state_q), 32'(DRAIN));
      for (int i = 0; i < 10 && (xfers - x0) < 1; i++) tick();
      chk("s3_xfers", 32'(xfers - x0), 32'd1);
      for (int i = 0; i < 5 && out_busy; i++) tick();
      chk("s3_busy", 32'(out_busy), 32'd0);
      chk("s3_idle", 32'(dut.state_q), 32'(IDLE));
      chk("s3_count", 32'(out_count), 32'd9);

      // Enabled against an empty fifo.
      r0 = reads; v0 = valid_seen;
      in_enable = 1'b1; in_fifo_empty = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("s4_reads", 32'(reads - r0), 32'd0);
      chk("s4_valid", 32'(valid_seen - v0), 32'd0);

      // Reset with two words held.
      r0 = reads;
      in_ready = 1'b0;
      up_q = '{8'h71, 8'h72, 8'h73};
      in_fifo_empty = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("s5_reads", 32'(reads - r0), 32'd2);
      chk("s5_held", 32'(out_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("s5_rst_valid", 32'(out_valid), 32'd0);
      chk("s5_rst_count", 32'(out_count), 32'd0);
      rst = 1'b0;
      exp_q.delete(); up_q.delete();
      in_fifo_empty = 1'b1; in_enable = 1'b0; in_ready = 1'b1;
      x0 = xfers;
      for (int i = 0; i < 6; i++) tick();
      chk("s5_no_deliver", 32'(xfers - x0), 32'd0);
      chk("s5_busy", 32'(out_busy), 32'd0);
      chk("read_while_empty", 32'(bad_rd), 32'd0);

      // Counter wrap on the depth-4 instance with an endless upstream source.
      en4 = 1'b1; ready4 = 1'b1; empty4 = 1'b0;
      for (int i = 0; i < 70000 && x4 < 65535; i++) begin
         #2;
         rd_s = rd4;
         if (valid4 && ready4) begin
            if (odata4 !== exp4) order_bad++;
            exp4 = exp4 + 8'd1;
            x4++;
         end
         @(posedge clk);
         #1;
         if (rd_s) begin
            data4 = nxt4;
            nxt4  = nxt4 + 8'd1;
         end else begin
            data4 = 8'hEE;
         end
         @(negedge clk);
      end
      chk("wrap_xfers", 32'(x4), 32'd65535);
      #2;
      chk("wrap_count_ffff", 32'(count4), 32'h0000_FFFF);
      chk("wrap_valid", 32'(valid4), 32'd1);
      if (valid4 && (odata4 !== exp4)) order_bad++;
      @(posedge clk);
      #1;
      chk("wrap_count_zero", 32'(count4), 32'd0);
      chk("wrap_order", 32'(order_bad), 32'd0);
      en4 = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
